// File: rtl/l1_l2_arbiter_if.sv
// Bus bundle between the L1 requestors, the L1-to-L2 arbiter and the shared L2 request port.
// Channel c of every flattened *_ch bus occupies bits [c*W +: W].
interface l1_l2_arbiter_if #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned TAG_W   = 18,
    parameter int unsigned INDEX_W = 8,
    parameter int unsigned DATA_W  = 512
);

    // L1 side, one slot per channel
    logic [NUM_CH-1:0]         read_L1_L2_ch;
    logic [NUM_CH-1:0]         write_L1_L2_ch;
    logic [NUM_CH*TAG_W-1:0]   tag_L1_L2_ch;
    logic [NUM_CH*INDEX_W-1:0] index_L1_L2_ch;
    logic [NUM_CH*TAG_W-1:0]   write_tag_L1_L2_ch;
    logic [NUM_CH*INDEX_W-1:0] write_index_L1_L2_ch;
    logic [NUM_CH*DATA_W-1:0]  write_data_L1_L2_ch;
    logic [NUM_CH-1:0]         ready_L2_L1_ch;

    // Shared L2 side
    logic                      read_L1_L2;
    logic                      write_L1_L2;
    logic [TAG_W-1:0]          tag_L1_L2;
    logic [INDEX_W-1:0]        index_L1_L2;
    logic [TAG_W-1:0]          write_tag_L1_L2;
    logic [INDEX_W-1:0]        write_index_L1_L2;
    logic [DATA_W-1:0]         write_data_L1_L2;
    logic                      ready_L2_L1;

    // Arbiter view: consumes L1 requests, masters the L2 port
    modport master (
        input  read_L1_L2_ch,
        input  write_L1_L2_ch,
        input  tag_L1_L2_ch,
        input  index_L1_L2_ch,
        input  write_tag_L1_L2_ch,
        input  write_index_L1_L2_ch,
        input  write_data_L1_L2_ch,
        output ready_L2_L1_ch,
        output read_L1_L2,
        output write_L1_L2,
        output tag_L1_L2,
        output index_L1_L2,
        output write_tag_L1_L2,
        output write_index_L1_L2,
        output write_data_L1_L2,
        input  ready_L2_L1
    );

    // Environment view: L1 requestors plus L2
    modport slave (
        output read_L1_L2_ch,
        output write_L1_L2_ch,
        output tag_L1_L2_ch,
        output index_L1_L2_ch,
        output write_tag_L1_L2_ch,
        output write_index_L1_L2_ch,
        output write_data_L1_L2_ch,
        input  ready_L2_L1_ch,
        input  read_L1_L2,
        input  write_L1_L2,
        input  tag_L1_L2,
        input  index_L1_L2,
        input  write_tag_L1_L2,
        input  write_index_L1_L2,
        input  write_data_L1_L2,
        output ready_L2_L1
    );

endinterface

// File: rtl/l1_l2_arbiter.sv
// N-channel round-robin arbiter from the L1 caches onto the single shared L2 request port.
// Optional ARB_WRITE_PRIORITY_EN: write-back requesters win arbitration over read-only ones.
module l1_l2_arbiter #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned TAG_W   = 18,
    parameter int unsigned INDEX_W = 8,
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned CH_W    = $clog2(NUM_CH)
) (
    input  logic            clk,
    input  logic            nrst,
    l1_l2_arbiter_if.master bus,
    output logic [CH_W-1:0] grant,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [CH_W-1:0]     ptr, ptr_d;
    logic [CH_W-1:0]     grant_d;
    logic                busy_d;

    logic                read_d, write_d;
    logic [TAG_W-1:0]    tag_d, write_tag_d;
    logic [INDEX_W-1:0]  index_d, write_index_d;
    logic [DATA_W-1:0]   write_data_d;

    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   cand;
    logic [CH_W-1:0]     sel;
    logic                sel_valid;

    logic [TAG_W-1:0]    tag_arr         [NUM_CH];
    logic [INDEX_W-1:0]  index_arr       [NUM_CH];
    logic [TAG_W-1:0]    write_tag_arr   [NUM_CH];
    logic [INDEX_W-1:0]  write_index_arr [NUM_CH];
    logic [DATA_W-1:0]   write_data_arr  [NUM_CH];

    // (base + off) mod NUM_CH for base, off < NUM_CH; safe for non-power-of-two NUM_CH
    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base,
                                                 input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_CH) begin
            s = s - NUM_CH;
        end
        return CH_W'(s);
    endfunction

    // Unpack the flattened channel buses
    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign tag_arr[c]         = bus.tag_L1_L2_ch[c*TAG_W +: TAG_W];
        assign index_arr[c]       = bus.index_L1_L2_ch[c*INDEX_W +: INDEX_W];
        assign write_tag_arr[c]   = bus.write_tag_L1_L2_ch[c*TAG_W +: TAG_W];
        assign write_index_arr[c] = bus.write_index_L1_L2_ch[c*INDEX_W +: INDEX_W];
        assign write_data_arr[c]  = bus.write_data_L1_L2_ch[c*DATA_W +: DATA_W];
    end

    assign req = bus.read_L1_L2_ch | bus.write_L1_L2_ch;

`ifdef ARB_WRITE_PRIORITY_EN
    // Pending dirty evictions shut read-only channels out of this round
    assign cand = (|bus.write_L1_L2_ch) ? bus.write_L1_L2_ch : req;
`else
    assign cand = req;
`endif

    // First candidate at or above ptr, wrapping
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!sel_valid && cand[wrap_add(ptr, i)]) begin
                sel       = wrap_add(ptr, i);
                sel_valid = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; everything holds unless changed below
    always_comb begin
        state_d       = state;
        ptr_d         = ptr;
        grant_d       = grant;
        read_d        = bus.read_L1_L2;
        write_d       = bus.write_L1_L2;
        tag_d         = bus.tag_L1_L2;
        index_d       = bus.index_L1_L2;
        write_tag_d   = bus.write_tag_L1_L2;
        write_index_d = bus.write_index_L1_L2;
        write_data_d  = bus.write_data_L1_L2;

        unique case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_d       = BUSY;
                    grant_d       = sel;
                    read_d        = bus.read_L1_L2_ch[sel];
                    write_d       = bus.write_L1_L2_ch[sel];
                    tag_d         = tag_arr[sel];
                    index_d       = index_arr[sel];
                    write_tag_d   = write_tag_arr[sel];
                    write_index_d = write_index_arr[sel];
                    write_data_d  = write_data_arr[sel];
                end
            end
            BUSY: begin
                if (bus.ready_L2_L1) begin
                    state_d = DONE;
                    ptr_d   = wrap_add(grant, 1);
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase

        busy_d = (state_d == BUSY);
    end

    // Completion is forwarded only to the granted channel and only while BUSY
    always_comb begin
        bus.ready_L2_L1_ch = '0;
        if (state == BUSY && bus.ready_L2_L1) begin
            bus.ready_L2_L1_ch[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state                 <= IDLE;
            ptr                   <= '0;
            grant                 <= '0;
            busy                  <= 1'b0;
            bus.read_L1_L2        <= 1'b0;
            bus.write_L1_L2       <= 1'b0;
            bus.tag_L1_L2         <= '0;
            bus.index_L1_L2       <= '0;
            bus.write_tag_L1_L2   <= '0;
            bus.write_index_L1_L2 <= '0;
            bus.write_data_L1_L2  <= '0;
        end else begin
            state                 <= state_d;
            ptr                   <= ptr_d;
            grant                 <= grant_d;
            busy                  <= busy_d;
            bus.read_L1_L2        <= read_d;
            bus.write_L1_L2       <= write_d;
            bus.tag_L1_L2         <= tag_d;
            bus.index_L1_L2       <= index_d;
            bus.write_tag_L1_L2   <= write_tag_d;
            bus.write_index_L1_L2 <= write_index_d;
            bus.write_data_L1_L2  <= write_data_d;
        end
    end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter: a 2-channel and a 3-channel instance on a shared clock/reset.
// Expected values follow ARB_WRITE_PRIORITY_EN when it is defined for the build.
module tb_l1_l2_arbiter;

    logic       clk;
    logic       nrst;
    logic [0:0] grant2;
    logic       busy2;
    logic [1:0] grant3;
    logic       busy3;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [0:0] exp_seq [4];

    l1_l2_arbiter_if #(.NUM_CH(2)) b2 ();
    l1_l2_arbiter_if #(.NUM_CH(3)) b3 ();

    l1_l2_arbiter #(.NUM_CH(2)) u_dut2 (
        .clk   (clk),
        .nrst  (nrst),
        .bus   (b2),
        .grant (grant2),
        .busy  (busy2)
    );

    l1_l2_arbiter #(.NUM_CH(3)) u_dut3 (
        .clk   (clk),
        .nrst  (nrst),
        .bus   (b3),
        .grant (grant3),
        .busy  (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Ready for one cycle, then the L1 side takes the given request vectors during DONE
    task automatic serve2(input logic [1:0] rd_keep, input logic [1:0] wr_keep);
        b2.ready_L2_L1 = 1'b1;
        tick();
        b2.ready_L2_L1    = 1'b0;
        b2.read_L1_L2_ch  = rd_keep;
        b2.write_L1_L2_ch = wr_keep;
        tick();
    endtask

    task automatic serve3(input logic [2:0] rd_keep);
        b3.ready_L2_L1 = 1'b1;
        tick();
        b3.ready_L2_L1   = 1'b0;
        b3.read_L1_L2_ch = rd_keep;
        tick();
    endtask

    initial begin
        nrst = 1'b0;
        b2.read_L1_L2_ch = '0;  b2.write_L1_L2_ch = '0;
        b2.tag_L1_L2_ch = '0;   b2.index_L1_L2_ch = '0;
        b2.write_tag_L1_L2_ch = '0; b2.write_index_L1_L2_ch = '0;
        b2.write_data_L1_L2_ch = '0; b2.ready_L2_L1 = 1'b0;
        b3.read_L1_L2_ch = '0;  b3.write_L1_L2_ch = '0;
        b3.tag_L1_L2_ch = '0;   b3.index_L1_L2_ch = '0;
        b3.write_tag_L1_L2_ch = '0; b3.write_index_L1_L2_ch = '0;
        b3.write_data_L1_L2_ch = '0; b3.ready_L2_L1 = 1'b0;
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state
        #2;
        chk("rst_read",  64'(b2.read_L1_L2), 64'h0);
        chk("rst_write", 64'(b2.write_L1_L2), 64'h0);
        chk("rst_tag",   64'(b2.tag_L1_L2), 64'h0);
        chk("rst_index", 64'(b2.index_L1_L2), 64'h0);
        chk("rst_wdata", b2.write_data_L1_L2[63:0], 64'h0);
        chk("rst_ready", 64'(b2.ready_L2_L1_ch), 64'h0);
        chk("rst_grant", 64'(grant2), 64'h0);
        chk("rst_busy",  64'(busy2), 64'h0);
        tick();
        tick();
        nrst = 1'b1;
        tick();

        // Single ch0 read, L2 ready 5 cycles after the request
        b2.read_L1_L2_ch = 2'b01;
        b2.tag_L1_L2_ch[0 +: 18] = 18'h1A2B3;
        b2.index_L1_L2_ch[0 +: 8] = 8'h45;
        tick();
        chk("a_read",  64'(b2.read_L1_L2), 64'h1);
        chk("a_write", 64'(b2.write_L1_L2), 64'h0);
        chk("a_tag",   64'(b2.tag_L1_L2), 64'h1A2B3);
        chk("a_index", 64'(b2.index_L1_L2), 64'h45);
        chk("a_grant", 64'(grant2), 64'h0);
        chk("a_busy",  64'(busy2), 64'h1);
        chk("a_ready_early", 64'(b2.ready_L2_L1_ch), 64'h0);
        tick();
        tick();
        tick();
        tick();
        b2.ready_L2_L1 = 1'b1;
        #1;
        chk("a_ready_route", 64'(b2.ready_L2_L1_ch), 64'h1);
        chk("a_read_hold",   64'(b2.read_L1_L2), 64'h1);
        tick();
        chk("a_done_read",  64'(b2.read_L1_L2), 64'h0);
        chk("a_done_busy",  64'(busy2), 64'h0);
        chk("a_done_ready", 64'(b2.ready_L2_L1_ch), 64'h0);
        chk("a_done_tag",   64'(b2.tag_L1_L2), 64'h1A2B3);
        b2.read_L1_L2_ch = 2'b00;
        tick();
        #1;
        chk("a_idle_ready", 64'(b2.ready_L2_L1_ch), 64'h0);
        b2.ready_L2_L1 = 1'b0;
        chk("a_idle_busy",  64'(busy2), 64'h0);
        chk("a_idle_read",  64'(b2.read_L1_L2), 64'h0);
        tick();

        // Both channels reading continuously: alternation, 2-cycle regrant
        b2.read_L1_L2_ch = 2'b11;
        b2.tag_L1_L2_ch[0 +: 18] = 18'h00A0A;
        b2.index_L1_L2_ch[0 +: 8] = 8'h0A;
        b2.tag_L1_L2_ch[18 +: 18] = 18'h00B0B;
        b2.index_L1_L2_ch[8 +: 8] = 8'h0B;
        tick();
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("b_grant%0d", g), 64'(grant2), 64'(exp_seq[g]));
            chk($sformatf("b_busy%0d", g),  64'(busy2), 64'h1);
            chk($sformatf("b_index%0d", g), 64'(b2.index_L1_L2),
                exp_seq[g] ? 64'h0B : 64'h0A);
            b2.ready_L2_L1 = 1'b1;
            #1;
            chk($sformatf("b_ready%0d", g), 64'(b2.ready_L2_L1_ch),
                exp_seq[g] ? 64'h2 : 64'h1);
            tick();
            b2.ready_L2_L1 = 1'b0;
            chk($sformatf("b_done_read%0d", g), 64'(b2.read_L1_L2), 64'h0);
            if (g == 3) b2.read_L1_L2_ch = 2'b00;
            tick();
            chk($sformatf("b_idle_busy%0d", g), 64'(busy2), 64'h0);
            tick();
        end
        chk("b_end_busy", 64'(busy2), 64'h0);

        // Asynchronous reset while ch1 is in flight
        b2.read_L1_L2_ch = 2'b10;
        b2.tag_L1_L2_ch[18 +: 18] = 18'h3FFFF;
        tick();
        chk("r_grant_pre", 64'(grant2), 64'h1);
        chk("r_busy_pre",  64'(busy2), 64'h1);
        b2.ready_L2_L1 = 1'b1;
        #2;
        nrst = 1'b0;
        #1;
        chk("r_read",  64'(b2.read_L1_L2), 64'h0);
        chk("r_tag",   64'(b2.tag_L1_L2), 64'h0);
        chk("r_grant", 64'(grant2), 64'h0);
        chk("r_busy",  64'(busy2), 64'h0);
        chk("r_ready", 64'(b2.ready_L2_L1_ch), 64'h0);
        tick();
        nrst = 1'b1;
        b2.ready_L2_L1 = 1'b0;
        b2.read_L1_L2_ch = 2'b00;
        tick();
        b2.read_L1_L2_ch = 2'b11;
        b2.tag_L1_L2_ch[0 +: 18] = 18'h00111;
        tick();
        chk("r_after_grant", 64'(grant2), 64'h0);
        chk("r_after_read",  64'(b2.read_L1_L2), 64'h1);
        chk("r_after_tag",   64'(b2.tag_L1_L2), 64'h00111);
        serve2(2'b00, 2'b00);

        // Channel input changes while BUSY are not forwarded
        b2.read_L1_L2_ch = 2'b10;
        b2.index_L1_L2_ch[8 +: 8] = 8'h10;
        tick();
        chk("c_grant", 64'(grant2), 64'h1);
        chk("c_index", 64'(b2.index_L1_L2), 64'h10);
        b2.index_L1_L2_ch[8 +: 8] = 8'h20;
        tick();
        chk("c_index_hold", 64'(b2.index_L1_L2), 64'h10);
        tick();
        b2.ready_L2_L1 = 1'b1;
        tick();
        chk("c_index_done", 64'(b2.index_L1_L2), 64'h10);
        chk("c_done_read",  64'(b2.read_L1_L2), 64'h0);
        b2.ready_L2_L1 = 1'b0;
        b2.read_L1_L2_ch = 2'b00;
        tick();

        // ch0 read vs ch1 write-back, ptr at 0
        b2.read_L1_L2_ch = 2'b01;
        b2.write_L1_L2_ch = 2'b10;
        b2.write_tag_L1_L2_ch[18 +: 18] = 18'h2AAAA;
        b2.write_index_L1_L2_ch[8 +: 8] = 8'h5C;
        b2.write_data_L1_L2_ch[512 +: 512] = {8{64'hDEAD_BEEF_0123_4567}};
        tick();
`ifdef ARB_WRITE_PRIORITY_EN
        chk("d_grant_first", 64'(grant2), 64'h1);
        chk("d_write_first", 64'(b2.write_L1_L2), 64'h1);
        chk("d_read_first",  64'(b2.read_L1_L2), 64'h0);
        chk("d_wtag",   64'(b2.write_tag_L1_L2), 64'h2AAAA);
        chk("d_windex", 64'(b2.write_index_L1_L2), 64'h5C);
        chk("d_wdata_lo", b2.write_data_L1_L2[63:0], 64'hDEAD_BEEF_0123_4567);
        chk("d_wdata_hi", b2.write_data_L1_L2[511:448], 64'hDEAD_BEEF_0123_4567);
        serve2(2'b01, 2'b00);
        tick();
        chk("d_grant_second", 64'(grant2), 64'h0);
        chk("d_read_second",  64'(b2.read_L1_L2), 64'h1);
        chk("d_write_second", 64'(b2.write_L1_L2), 64'h0);
        serve2(2'b00, 2'b00);
`else
        chk("d_grant_first", 64'(grant2), 64'h0);
        chk("d_read_first",  64'(b2.read_L1_L2), 64'h1);
        chk("d_write_first", 64'(b2.write_L1_L2), 64'h0);
        serve2(2'b00, 2'b10);
        tick();
        chk("d_grant_second", 64'(grant2), 64'h1);
        chk("d_write_second", 64'(b2.write_L1_L2), 64'h1);
        chk("d_read_second",  64'(b2.read_L1_L2), 64'h0);
        chk("d_wtag",   64'(b2.write_tag_L1_L2), 64'h2AAAA);
        chk("d_windex", 64'(b2.write_index_L1_L2), 64'h5C);
        chk("d_wdata_lo", b2.write_data_L1_L2[63:0], 64'hDEAD_BEEF_0123_4567);
        chk("d_wdata_hi", b2.write_data_L1_L2[511:448], 64'hDEAD_BEEF_0123_4567);
        serve2(2'b00, 2'b00);
`endif

        // Combined write-back + fill from one channel keeps both bits
        b2.read_L1_L2_ch = 2'b01;
        b2.write_L1_L2_ch = 2'b01;
        tick();
        chk("e_grant", 64'(grant2), 64'h0);
        chk("e_read",  64'(b2.read_L1_L2), 64'h1);
        chk("e_write", 64'(b2.write_L1_L2), 64'h1);
        serve2(2'b00, 2'b00);

        // Three channels: move ptr to 2, then wrap to ch0 before ch1
        b3.read_L1_L2_ch = 3'b010;
        tick();
        chk("f_grant_ch1", 64'(grant3), 64'h1);
        chk("f_busy",      64'(busy3), 64'h1);
        serve3(3'b000);
        b3.read_L1_L2_ch = 3'b011;
        tick();
        chk("f_grant_wrap", 64'(grant3), 64'h0);
        b3.ready_L2_L1 = 1'b1;
        #1;
        chk("f_ready_wrap", 64'(b3.ready_L2_L1_ch), 64'h1);
        serve3(3'b010);
        tick();
        chk("f_grant_next", 64'(grant3), 64'h1);
        chk("f_read_next",  64'(b3.read_L1_L2), 64'h1);
        serve3(3'b000);
        chk("f_idle_busy", 64'(busy3), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
